// File: rtl/bambu_slave_port_master.sv
// -----------------------------------------------------------------------------
// bambu_slave_port_master
//
// Burst initiator for one channel of a Bambu-generated accelerator's slave
// memory port. A host-side loader hands over burst commands; the block then
// walks the accelerator's slave port one beat at a time. Write bursts preload
// the accelerator's internal memories from the wr_* stream; read bursts drain
// results onto the rd_* stream. The accelerator's own memory responder is
// used unchanged, so the accelerator can run without a simulation harness.
//
// Ports
//   clock, reset        rising-edge clock; asynchronous active-low reset
//   cmd_valid/cmd_ready command handshake
//   cmd_we              1 = write burst, 0 = read burst
//   cmd_addr            byte address of the first beat
//   cmd_len             number of beats (0 = empty command, done only)
//   wr_valid/wr_ready   write-data handshake, one beat per transfer
//   wr_data             write beat
//   rd_valid/rd_data    read beat, one-cycle valid, no backpressure
//   busy                a command is in progress
//   done                one-cycle pulse at the end of each command
//   error               one-cycle pulse together with done when a beat timed out
//   S_oe_ram, S_we_ram  read / write strobes towards the accelerator
//   S_addr_ram          beat address
//   S_Wdata_ram         write beat towards the accelerator
//   S_data_ram_size     beat size in bits, 0 while no strobe is up
//   Sout_Rdata_ram      read beat from the accelerator
//   Sout_DataRdy        accelerator completes the current beat
// -----------------------------------------------------------------------------
module bambu_slave_port_master #(
   parameter int ADDR_W  = 11,
   parameter int DATA_W  = 8,
   parameter int SIZE_W  = 4,
   parameter int LEN_W   = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_we,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              S_oe_ram,
   output logic              S_we_ram,
   output logic [ADDR_W-1:0] S_addr_ram,
   output logic [DATA_W-1:0] S_Wdata_ram,
   output logic [SIZE_W-1:0] S_data_ram_size,
   input  logic [DATA_W-1:0] Sout_Rdata_ram,
   input  logic              Sout_DataRdy
);

   localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);
   localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);
   localparam logic [LEN_W-1:0]  LEN_ZERO  = LEN_W'(0);
   localparam logic [TMO_W-1:0]  TMO_ONE   = TMO_W'(1);
   localparam logic [TMO_W-1:0]  TMO_ZERO  = TMO_W'(0);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
   localparam logic [SIZE_W-1:0] BEAT_SIZE = SIZE_W'(DATA_W);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WDATA = 2'd1,
      ST_REQ   = 2'd2,
      ST_FIN   = 2'd3
   } state_t;

   state_t              state_r;
   state_t              state_s;
   logic                we_r;
   logic [ADDR_W-1:0]   addr_r;
   logic [LEN_W-1:0]    cnt_r;
   logic [DATA_W-1:0]   wdat_r;
   logic [TMO_W-1:0]    tmo_r;
   logic                err_r;
   logic                rd_valid_r;
   logic [DATA_W-1:0]   rd_data_r;

   // State register; reset discards any burst in flight without a done pulse
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (cmd_valid) begin
               if (cmd_len == LEN_ZERO) begin
                  state_s = ST_FIN;
               end else if (cmd_we) begin
                  state_s = ST_WDATA;
               end else begin
                  state_s = ST_REQ;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WDATA: begin
            if (wr_valid) begin
               state_s = ST_REQ;
            end else begin
               state_s = ST_WDATA;
            end
         end
         ST_REQ: begin
            // A ready in the last allowed cycle still completes the beat
            if (Sout_DataRdy) begin
               if (cnt_r == LEN_ONE) begin
                  state_s = ST_FIN;
               end else if (we_r) begin
                  state_s = ST_WDATA;
               end else begin
                  state_s = ST_REQ;
               end
            end else if (tmo_r == TMO_LAST) begin
               state_s = ST_FIN;
            end else begin
               state_s = ST_REQ;
            end
         end
         ST_FIN: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Burst bookkeeping: command latch, beat address/count, wait timer, read capture
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         we_r       <= 1'b0;
         addr_r     <= '0;
         cnt_r      <= '0;
         wdat_r     <= '0;
         tmo_r      <= '0;
         err_r      <= 1'b0;
         rd_valid_r <= 1'b0;
         rd_data_r  <= '0;
      end else begin
         rd_valid_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               tmo_r <= TMO_ZERO;
               err_r <= 1'b0;
               if (cmd_valid) begin
                  we_r   <= cmd_we;
                  addr_r <= cmd_addr;
                  cnt_r  <= cmd_len;
               end
            end
            ST_WDATA: begin
               tmo_r <= TMO_ZERO;
               if (wr_valid) begin
                  wdat_r <= wr_data;
               end
            end
            ST_REQ: begin
               if (Sout_DataRdy) begin
                  // Address wraps naturally at the channel width
                  addr_r <= addr_r + ADDR_STEP;
                  cnt_r  <= cnt_r - LEN_ONE;
                  tmo_r  <= TMO_ZERO;
                  if (!we_r) begin
                     rd_data_r  <= Sout_Rdata_ram;
                     rd_valid_r <= 1'b1;
                  end
               end else if (tmo_r == TMO_LAST) begin
                  // Remaining beats are abandoned; flag is shown in FIN
                  tmo_r <= TMO_ZERO;
                  err_r <= 1'b1;
               end else begin
                  tmo_r <= tmo_r + TMO_ONE;
               end
            end
            ST_FIN: begin
               tmo_r <= TMO_ZERO;
               err_r <= 1'b0;
            end
            default: begin
               tmo_r <= TMO_ZERO;
               err_r <= 1'b0;
            end
         endcase
      end
   end

   // Output decode from registered state only, so strobes are glitch-free and
   // stay stable for the whole beat; cmd_ready is additionally held low while
   // reset is asserted
   always_comb begin
      cmd_ready       = 1'b0;
      wr_ready        = 1'b0;
      busy            = 1'b1;
      done            = 1'b0;
      error           = 1'b0;
      S_oe_ram        = 1'b0;
      S_we_ram        = 1'b0;
      S_addr_ram      = '0;
      S_Wdata_ram     = '0;
      S_data_ram_size = '0;
      case (state_r)
         ST_IDLE: begin
            cmd_ready = reset;
            busy      = 1'b0;
         end
         ST_WDATA: begin
            wr_ready = 1'b1;
         end
         ST_REQ: begin
            S_oe_ram        = ~we_r;
            S_we_ram        = we_r;
            S_addr_ram      = addr_r;
            S_Wdata_ram     = wdat_r;
            S_data_ram_size = BEAT_SIZE;
         end
         ST_FIN: begin
            done  = 1'b1;
            error = err_r;
         end
         default: begin
            busy = 1'b1;
         end
      endcase
   end

   assign rd_valid = rd_valid_r;
   assign rd_data  = rd_data_r;

endmodule

// File: tb/tb_bambu_slave_port_master.sv
module tb_bambu_slave_port_master;

   logic        clk;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_we;
   logic [10:0] cmd_addr;
   logic [15:0] cmd_len;
   logic        wr_valid;
   logic        wr_ready;
   logic [7:0]  wr_data;
   logic        rd_valid;
   logic [7:0]  rd_data;
   logic        busy;
   logic        done;
   logic        error;
   logic        s_oe;
   logic        s_we;
   logic [10:0] s_addr;
   logic [7:0]  s_wdata;
   logic [3:0]  s_size;
   logic [7:0]  s_rdata;
   logic        s_rdy;

   bambu_slave_port_master #(
      .ADDR_W(11), .DATA_W(8), .SIZE_W(4), .LEN_W(16), .TIMEOUT(8)
   ) dut (
      .clock(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .busy(busy), .done(done), .error(error),
      .S_oe_ram(s_oe), .S_we_ram(s_we), .S_addr_ram(s_addr),
      .S_Wdata_ram(s_wdata), .S_data_ram_size(s_size),
      .Sout_Rdata_ram(s_rdata), .Sout_DataRdy(s_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   // ---------------- accelerator-side responder (memory with latency) -----
   logic [7:0]  mem [0:2047];
   logic [7:0]  ref_mem [0:2047];
   logic        fill_en = 1'b0;
   logic        pl_en = 1'b0;
   logic [10:0] pl_addr = 11'd0;
   logic [7:0]  pl_data = 8'd0;
   logic        never_rdy = 1'b0;
   int          lat = 1;
   int          rcnt = 0;
   wire         stb = s_oe | s_we;

   function automatic logic [7:0] fill_val(input int i);
      return 8'((i * 29 + 7) & 255);
   endfunction

   assign s_rdy   = stb && !never_rdy && (rcnt >= lat - 1);
   assign s_rdata = mem[s_addr];

   always @(posedge clk) begin
      if (fill_en) begin
         for (int i = 0; i < 2048; i++) mem[i] <= fill_val(i);
      end else if (pl_en) begin
         mem[pl_addr] <= pl_data;
      end else if (stb && s_rdy && s_we) begin
         mem[s_addr] <= s_wdata;
      end
      if (stb && s_rdy) rcnt <= 0;
      else if (stb)     rcnt <= rcnt + 1;
      else              rcnt <= 0;
   end

   // ---------------- monitor ----------------------------------------------
   logic        mon_clr = 1'b0;
   int stb_n, oe_n, we_n, both_n, size_bad, beat_n, rdv_n, done_n, done_cyc;
   int err_at_done, err_alone, rdv_first;
   logic [10:0] addr_log [0:15];
   logic [7:0]  rd_log [0:15];

   always @(negedge clk) begin
      if (mon_clr) begin
         stb_n <= 0; oe_n <= 0; we_n <= 0; both_n <= 0; size_bad <= 0;
         beat_n <= 0; rdv_n <= 0; done_n <= 0; done_cyc <= 0;
         err_at_done <= 0; err_alone <= 0; rdv_first <= -1;
      end else begin
         if (stb) stb_n <= stb_n + 1;
         if (s_oe) oe_n <= oe_n + 1;
         if (s_we) we_n <= we_n + 1;
         if (s_oe && s_we) both_n <= both_n + 1;
         if ((!stb && s_size != 4'd0) || (stb && s_size != 4'd8)) size_bad <= size_bad + 1;
         if (stb && s_rdy && beat_n < 16) begin
            addr_log[beat_n] <= s_addr;
            beat_n <= beat_n + 1;
         end
         if (rd_valid && rdv_n < 16) begin
            rd_log[rdv_n] <= rd_data;
            rdv_n <= rdv_n + 1;
            if (rdv_first < 0) rdv_first <= cyc;
         end
         if (done) begin
            done_n <= done_n + 1;
            done_cyc <= cyc;
            err_at_done <= int'(error);
         end
         if (error && !done) err_alone <= err_alone + 1;
      end
   end

   // ---------------- helpers ----------------------------------------------
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clear_mon();
      @(posedge clk); #1 mon_clr = 1'b1;
      @(posedge clk); #1 mon_clr = 1'b0;
   endtask

   task automatic preload(input logic [10:0] a, input logic [7:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      ref_mem[a] = d;
      @(posedge clk); #1 pl_en = 1'b0;
   endtask

   int acc_cyc = 0;

   task automatic send_cmd(input bit we, input logic [10:0] a, input logic [15:0] n);
      int k;
      cmd_we = we; cmd_addr = a; cmd_len = n; cmd_valid = 1'b1;
      k = 0;
      @(negedge clk);
      while (!cmd_ready && k < 100) begin @(negedge clk); k++; end
      acc_cyc = cyc;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic feed(input int n, input int stall, input logic [63:0] wd);
      int k;
      for (int i = 0; i < n; i++) begin
         wr_data = wd[8*i +: 8];
         if (i == 1 && stall > 0) begin
            wr_valid = 1'b0;
            k = 0;
            @(negedge clk);
            while (!wr_ready && k < 100) begin @(negedge clk); k++; end
            repeat (stall - 1) @(posedge clk);
            @(posedge clk); #1;
         end
         wr_valid = 1'b1;
         k = 0;
         @(negedge clk);
         while (!wr_ready && k < 100) begin @(negedge clk); k++; end
         @(posedge clk); #1;
      end
      wr_valid = 1'b0;
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (done_n == 0 && k < 200) begin @(negedge clk); k++; end
      @(negedge clk);
   endtask

   // Reference timing: empty command finishes right away; otherwise each beat
   // costs its latency, plus one data cycle (and any stall) per write beat.
   function automatic int model_done(input bit we, input int n, input int l, input int stall);
      if (n == 0) return 1;
      if (we) return 1 + n * (1 + l) + stall;
      return 1 + n * l;
   endfunction

   task automatic run_vec(input string nm, input bit we, input logic [10:0] a, input int n,
                          input int l, input int stall, input logic [63:0] wd, input int exp_done);
      logic [10:0] ea;
      logic [7:0]  eb;
      lat = l;
      clear_mon();
      fork
         send_cmd(we, a, 16'(n));
         begin
            if (we && n > 0) feed(n, stall, wd);
         end
      join
      wait_done();
      chk({nm, " done_cnt"}, 64'(done_n), 64'd1);
      chk({nm, " done_off"}, 64'(done_cyc - acc_cyc), 64'(exp_done));
      chk({nm, " error"}, 64'(err_at_done + err_alone), 64'd0);
      chk({nm, " beats"}, 64'(beat_n), 64'(n));
      chk({nm, " strobe_cycles"}, 64'(stb_n), 64'(n * l));
      chk({nm, " both_strobes"}, 64'(both_n), 64'd0);
      chk({nm, " size"}, 64'(size_bad), 64'd0);
      if (we) chk({nm, " oe_in_write"}, 64'(oe_n), 64'd0);
      else    chk({nm, " we_in_read"}, 64'(we_n), 64'd0);
      for (int i = 0; i < n; i++) begin
         ea = a + 11'(i);
         chk($sformatf("%s addr%0d", nm, i), 64'(addr_log[i]), 64'(ea));
         if (we) begin
            eb = wd[8*i +: 8];
            chk($sformatf("%s mem%0d", nm, i), 64'(mem[ea]), 64'(eb));
            ref_mem[ea] = eb;
         end else begin
            chk($sformatf("%s rd%0d", nm, i), 64'(rd_log[i]), 64'(ref_mem[ea]));
         end
      end
      chk({nm, " rd_count"}, 64'(rdv_n), we ? 64'd0 : 64'(n));
      if (!we && n > 0) chk({nm, " rd_first"}, 64'(rdv_first - acc_cyc), 64'(l + 1));
      chk({nm, " idle"}, {63'd0, busy}, 64'd0);
      chk({nm, " ready"}, {63'd0, cmd_ready}, 64'd1);
   endtask

   typedef struct {
      bit          we;
      logic [10:0] addr;
      int          len;
      int          lat;
      int          stall;
      logic [63:0] wd;
      int          exp_done;
   } vec_t;

   vec_t vt [6];

   initial begin
      int k;
      logic [63:0] rwd;
      bit rwe;
      int rn, rl, rs;
      logic [10:0] ra;

      vt[0] = '{1'b0, 11'h180, 4, 2, 0, 64'h0, 9};
      vt[1] = '{1'b1, 11'h200, 3, 2, 2, 64'hFF5AA5, 12};
      vt[2] = '{1'b0, 11'h050, 0, 1, 0, 64'h0, 1};
      vt[3] = '{1'b0, 11'h7FE, 3, 1, 0, 64'h0, 4};
      vt[4] = '{1'b1, 11'h3FF, 2, 1, 0, 64'hC33C, 5};
      vt[5] = '{1'b0, 11'h200, 3, 3, 0, 64'h0, 10};

      reset = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 11'd0; cmd_len = 16'd0;
      wr_valid = 1'b0; wr_data = 8'd0;
      for (int i = 0; i < 2048; i++) ref_mem[i] = fill_val(i);
      fill_en = 1'b1;
      @(posedge clk); #1 fill_en = 1'b0;
      mon_clr = 1'b1;
      @(negedge clk);
      chk("rst cmd_ready", {63'd0, cmd_ready}, 64'd0);
      chk("rst outs", {35'd0, wr_ready, rd_valid, rd_data, busy, done, error, s_oe, s_we,
                       s_addr, s_size}, 64'd0);
      chk("rst wdata", 64'(s_wdata), 64'd0);
      #2 reset = 1'b1;
      #1;
      chk("rel cmd_ready", {63'd0, cmd_ready}, 64'd1);
      @(posedge clk); #1 mon_clr = 1'b0;

      preload(11'h180, 8'h11);
      preload(11'h181, 8'h22);
      preload(11'h182, 8'h33);
      preload(11'h183, 8'h44);

      for (int i = 0; i < 6; i++) begin
         run_vec($sformatf("vec%0d", i), vt[i].we, vt[i].addr, vt[i].len, vt[i].lat,
                 vt[i].stall, vt[i].wd, vt[i].exp_done);
         if (i == 0) begin
            chk("read rd0", 64'(rd_log[0]), 64'h11);
            chk("read rd3", 64'(rd_log[3]), 64'h44);
         end
         if (i == 3) chk("wrap addr2", 64'(addr_log[2]), 64'h000);
      end

      // Timeout: responder never answers
      never_rdy = 1'b1; lat = 1;
      clear_mon();
      send_cmd(1'b0, 11'h010, 16'd2);
      wait_done();
      chk("tmo strobe_cycles", 64'(stb_n), 64'd8);
      chk("tmo done_off", 64'(done_cyc - acc_cyc), 64'd9);
      chk("tmo error_with_done", 64'(err_at_done), 64'd1);
      chk("tmo error_alone", 64'(err_alone), 64'd0);
      chk("tmo rd_count", 64'(rdv_n), 64'd0);
      chk("tmo idle", {62'd0, busy, ~cmd_ready}, 64'd0);
      never_rdy = 1'b0;

      // Reset during the second beat of a 4-beat read
      lat = 2;
      clear_mon();
      send_cmd(1'b0, 11'h020, 16'd4);
      k = 0;
      while (cyc != acc_cyc + 3 && k < 50) begin @(negedge clk); k++; end
      chk("mid strobe", {63'd0, s_oe}, 64'd1);
      reset = 1'b0;
      #1;
      chk("mid rst strobes", {52'd0, s_oe, s_we, s_addr[9:0]}, 64'd0);
      chk("mid rst status", {61'd0, busy, cmd_ready, done}, 64'd0);
      #3 reset = 1'b1;
      repeat (12) @(negedge clk);
      chk("mid no_done", 64'(done_n), 64'd0);
      chk("mid idle", {62'd0, busy, cmd_ready}, 64'd1);
      run_vec("post_rst", 1'b0, 11'h123, 1, 1, 0, 64'h0, 2);

      // Randomized commands against the reference model
      for (int r = 0; r < 25; r++) begin
         rwe = 1'($urandom_range(0, 1));
         ra  = 11'($urandom_range(0, 2047));
         rn  = int'($urandom_range(0, 5));
         rl  = int'($urandom_range(1, 4));
         rs  = (rwe && rn >= 2) ? int'($urandom_range(0, 2)) : 0;
         rwd = {$urandom, $urandom};
         run_vec($sformatf("rnd%0d", r), rwe, ra, rn, rl, rs, rwd, model_done(rwe, rn, rl, rs));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/bambu_slave_port_master.md
# bambu_slave_port_master

Synthesizable initiator for one channel of the Bambu slave memory port (`S_oe_ram`/`S_we_ram`/`S_addr_ram`/`S_Wdata_ram`/`S_data_ram_size` in, `Sout_Rdata_ram`/`Sout_DataRdy` out) of a generated accelerator. It accepts burst commands from a host-side loader and drives the accelerator's slave port beat by beat. Writes preload input arrays into the accelerator's internal memories; reads drain results. The accelerator-side memory responder remains unchanged; this block lets the same accelerator run without the simulation harness.

## Interface
Parameters:
- `ADDR_W`, 11, channel address width in bytes.
- `DATA_W`, 8, beat width in bits; must be a multiple of 8.
- `SIZE_W`, 4, width of `S_data_ram_size`.
- `LEN_W`, 16, burst length counter width.
- `TIMEOUT`, 1024, maximum number of cycles to wait for `Sout_DataRdy` per beat.

Ports:
- `clock` in 1: the single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_we` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr` in ADDR_W: byte address of the first beat.
- `cmd_len` in LEN_W: number of beats.
- `wr_valid` in 1 / `wr_ready` out 1 / `wr_data` in DATA_W: write-data stream.
- `rd_valid` out 1 / `rd_data` out DATA_W: read-data stream. There is no backpressure on this stream.
- `busy` out 1: a command is in progress.
- `done` out 1: one-cycle pulse at the end of a command.
- `error` out 1: one-cycle pulse, coincident with `done`, when a beat times out.
- `S_oe_ram` out 1, `S_we_ram` out 1, `S_addr_ram` out ADDR_W, `S_Wdata_ram` out DATA_W, `S_data_ram_size` out SIZE_W: request to the accelerator.
- `Sout_Rdata_ram` in DATA_W, `Sout_DataRdy` in 1: response from the accelerator.

## Operation
- States: IDLE, WDATA, REQ, FIN.
- IDLE:
  - `cmd_ready`=1.
  - On accept, latch `cmd_we`, `cmd_addr` and `cmd_len` into `we_r`, `addr_r` and `cnt_r`.
  - If `cmd_len`=0, go to FIN.
  - Otherwise go to WDATA if `we`, else REQ.
- WDATA:
  - `wr_ready`=1.
  - On `wr_valid`, latch `wr_data` into `wdat_r` and go to REQ.
- REQ:
  - Drive `S_oe_ram`=!`we_r`, `S_we_ram`=`we_r`, `S_addr_ram`=`addr_r`, `S_Wdata_ram`=`wdat_r`, `S_data_ram_size`=DATA_W.
  - Hold all of these stable until `Sout_DataRdy` is sampled 1.
  - On the ready edge:
    - `addr_r` += DATA_W/8, wrapping modulo 2^ADDR_W.
    - `cnt_r` −= 1.
    - `tmo_r` clears.
    - For a read, register `rd_data`=`Sout_Rdata_ram` with `rd_valid`=1 for one cycle.
  - Next state after the ready edge: FIN if `cnt_r` was 1; else WDATA for writes; else stay in REQ with the new address (back-to-back reads).
- Timeout in REQ: `tmo_r` counts every cycle without ready. When it reaches TIMEOUT−1, drop the strobes, assert the error pulse and go to FIN. The remaining beats are abandoned.
- FIN: `done`=1 for one cycle, then return to IDLE.
- `busy` = state ≠ IDLE.
- Strobe timing:
  - `S_oe_ram` and `S_we_ram` are never 1 simultaneously.
  - Strobes are 0 outside REQ.
  - Strobes are also 0 during the WDATA gap between write beats.
- `S_data_ram_size` is 0 whenever no strobe is asserted.

## Timing
- Reset (asynchronous, `reset`=0), forced immediately:
  - state=IDLE.
  - `cmd_ready`=0 while `reset`=0 and 1 after release.
  - All other outputs 0: `wr_ready`, `rd_valid`, `rd_data`, `busy`, `done`, `error`, and all `S_*` outputs.
  - A burst in flight is discarded with no `done`.
- Read beat:
  - Strobe appears in the cycle after command accept.
  - With a responder that answers after L cycles (ready in the L-th strobe cycle), `rd_valid` appears at accept+L+1.
  - Consecutive beats of a burst take L cycles each.
- Write beat: 1 WDATA cycle (minimum, if `wr_valid` is already high) + L REQ cycles.
- `done` rises in the cycle after the last ready edge.
- Next command is accepted no earlier than the cycle after `done`.
- `cmd_len`=0: `done` pulses at accept+1 with no strobe.
- `Sout_DataRdy` outside REQ is ignored.
- `Sout_DataRdy` in the first REQ cycle (L=1) is legal and completes the beat.

## Test plan
- Read burst with a responder model of L=2:
  - Stimulus: `cmd_addr`=0x180, `cmd_len`=4, memory bytes 0x11, 0x22, 0x33, 0x44.
  - Required: `rd_data` = 0x11, 0x22, 0x33, 0x44; addresses 0x180–0x183; `done` at accept+9.
- Write burst:
  - Stimulus: `cmd_addr`=0x200, `cmd_len`=3, data A5, 5A, FF; `wr_valid` stalled 2 cycles before the second beat.
  - Required: memory holds A5/5A/FF at 0x200–0x202; `S_oe_ram` stays 0; strobe drops during the stall.
- Zero length:
  - Stimulus: `cmd_len`=0.
  - Required: `done`=1 at accept+1; no strobe ever asserted; `error`=0.
- Timeout:
  - Stimulus: TIMEOUT=8, responder never ready, read `cmd_len`=2.
  - Required: strobe high exactly 8 cycles; `error` and `done` pulse together; no `rd_valid`; back in IDLE.
- Address wrap:
  - Stimulus: `cmd_addr`=0x7FE, `cmd_len`=3, read.
  - Required: addresses 0x7FE, 0x7FF, 0x000.
- Reset mid-burst:
  - Stimulus: assert `reset`=0 for half a cycle during the second beat of a 4-beat read.
  - Required: all strobes 0 immediately; no `done`; a new command is accepted normally after release.
